// File: rtl/arb8_rr_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// The master side drives the request lines; the arbiter (slave) returns grants.
interface arb8_rr_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_code;
  logic       grant_valid;
  logic       preempt;

  modport master (
    output req,
    input  grant,
    input  grant_code,
    input  grant_valid,
    input  preempt
  );

  modport slave (
    input  req,
    output grant,
    output grant_code,
    output grant_valid,
    output preempt
  );
endinterface

// File: rtl/arb8_rr_ctrl.sv
// Eight-way round-robin arbiter with registered one-hot grant, binary code,
// and an optional hold limit that forces rotation when others are waiting.
module arb8_rr_ctrl #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  arb8_rr_if.slave   bus
);

  typedef enum logic {IDLE, OWN} state_t;

  // Value the hold counter saturates at; with the limit disabled it simply
  // stops at its maximum so it never wraps back into a small count.
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_LIM;

  state_t            state_reg, state_next;
  logic [7:0]        grant_reg, grant_next;
  logic [2:0]        code_reg, code_next;
  logic              valid_reg, valid_next;
  logic              preempt_reg, preempt_next;
  logic [2:0]        ptr_reg, ptr_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;

  // First set bit of r scanning upward from start, wrapping 7->0.
  // Result is {found, index}.
  function automatic logic [3:0] search(input logic [7:0] r, input logic [2:0] start);
    logic       found;
    logic [2:0] win;
    logic [2:0] idx;
    found = 1'b0;
    win   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = start + 3'(k);
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  logic [7:0] others;
  logic [2:0] owner_next_start;
  logic [3:0] idle_pick;
  logic [3:0] own_pick;
  logic       limit_hit;

  assign others           = bus.req & ~grant_reg;
  assign owner_next_start = code_reg + 3'd1;
  assign idle_pick        = search(bus.req, ptr_reg);
  // Owner bit is excluded, which covers both release (owner bit already low)
  // and forced rotation (owner must not win its own preemption).
  assign own_pick         = search(others, owner_next_start);
  assign limit_hit        = (MAX_HOLD != 0) && (hold_reg == HOLD_LIM);

  // Next-state and next-output decode for the IDLE/OWN controller.
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    code_next    = code_reg;
    valid_next   = valid_reg;
    preempt_next = 1'b0;
    ptr_next     = ptr_reg;
    hold_next    = hold_reg;

    case (state_reg)
      IDLE: begin
        if (idle_pick[3]) begin
          state_next = OWN;
          grant_next = 8'd1 << idle_pick[2:0];
          code_next  = idle_pick[2:0];
          valid_next = 1'b1;
          ptr_next   = idle_pick[2:0] + 3'd1;
          hold_next  = HOLD_W'(1);
        end
      end
      OWN: begin
        if (!bus.req[code_reg]) begin
          // Owner released: hand over directly or go idle; never a preempt.
          if (own_pick[3]) begin
            grant_next = 8'd1 << own_pick[2:0];
            code_next  = own_pick[2:0];
            ptr_next   = own_pick[2:0] + 3'd1;
            hold_next  = HOLD_W'(1);
          end else begin
            state_next = IDLE;
            grant_next = 8'd0;
            code_next  = 3'd0;
            valid_next = 1'b0;
            hold_next  = '0;
          end
        end else if (limit_hit && own_pick[3]) begin
          grant_next   = 8'd1 << own_pick[2:0];
          code_next    = own_pick[2:0];
          ptr_next     = own_pick[2:0] + 3'd1;
          hold_next    = HOLD_W'(1);
          preempt_next = 1'b1;
        end else if (hold_reg != HOLD_SAT) begin
          hold_next = hold_reg + HOLD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 8'd0;
        code_next  = 3'd0;
        valid_next = 1'b0;
        hold_next  = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      grant_reg   <= 8'd0;
      code_reg    <= 3'd0;
      valid_reg   <= 1'b0;
      preempt_reg <= 1'b0;
      ptr_reg     <= 3'd0;
      hold_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      code_reg    <= code_next;
      valid_reg   <= valid_next;
      preempt_reg <= preempt_next;
      ptr_reg     <= ptr_next;
      hold_reg    <= hold_next;
    end
  end

  assign bus.grant       = grant_reg;
  assign bus.grant_code  = code_reg;
  assign bus.grant_valid = valid_reg;
  assign bus.preempt     = preempt_reg;

endmodule

// File: doc/arb8_rr_ctrl.md
Name: arb8_rr_ctrl

Overview:
Eight-way round-robin arbiter that shares one downstream resource (bus or datapath slot) between eight requesters. It issues a registered one-hot grant plus its 3-bit binary index, so the grant code always matches the standard 8x3 one-hot encoding. A grant is held until the owner drops its request. An optional hold limit forces rotation so no requester can starve the others.

Parameters:
MAX_HOLD, 16, maximum consecutive grant cycles before forced rotation when others are waiting; 0 disables the limit.
HOLD_W, 5, width of the hold counter; MAX_HOLD must be less than 2^HOLD_W.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  8  request lines; req[i] high means requester i wants the resource.
grant  output  8  registered one-hot grant; all zeros when no owner.
grant_code  output  3  binary index of the set grant bit; 0 when grant_valid is low.
grant_valid  output  1  high when exactly one grant bit is set.
preempt  output  1  one-cycle pulse on the edge where a forced rotation moves the grant.

Behaviour:
- Reset (asynchronous, immediate, including mid-grant):
  - grant=0, grant_code=0, grant_valid=0, preempt=0.
  - Round-robin pointer ptr=0, hold_cnt=0, state IDLE.
- Invariants:
  - grant is one-hot or zero.
  - grant_valid equals OR of grant.
  - grant_code equals the index of the set bit whenever grant_valid=1.
  - All outputs are registered; no combinational path from req to outputs.
- Search function: pick the first i with req[i]=1, scanning from a start index upward modulo 8 (start, start+1, ..., 7, 0, ...).
- State IDLE:
  - If req==0, stay in IDLE with outputs zero.
  - Otherwise, on the next edge, grant the search winner starting from ptr. Set state OWN, hold_cnt=1, and ptr = winner+1 (mod 8).
  - Latency: req sampled at edge k produces grant visible after edge k.
- State OWN, owner o, evaluated at each edge:
  - Release: req[o]=0.
    - If any other req bit is set, grant moves directly to the search winner starting from o+1, with no idle cycle. Set hold_cnt=1 and ptr = winner+1.
    - If no other req bit is set, grant=0, grant_code=0, grant_valid=0, and state returns to IDLE.
    - preempt=0 in both cases.
  - Hold: req[o]=1 and no forced rotation due. Grant is unchanged, and hold_cnt increments, saturating at MAX_HOLD.
  - Forced rotation: MAX_HOLD!=0, hold_cnt==MAX_HOLD, req[o]=1, and another req bit is set.
    - Grant moves to the search winner starting from o+1; the owner is excluded from this search.
    - preempt=1 for exactly one cycle, hold_cnt=1, ptr = winner+1.
    - The preempted owner re-enters arbitration normally.
  - Limit reached but no other requester: the owner keeps the grant, hold_cnt stays at MAX_HOLD, and no preempt is issued.
- Simultaneous events:
  - Owner release and limit on the same edge: treat as a normal release, preempt=0.
  - Multiple new requests on the same edge are resolved purely by search order from the start index.
  - Requests arriving while another requester owns the grant are queued only by their level; there is no latching.
- Wrap-around: ptr and the search start wrap 7->0. Priority after a grant to requester 7 starts at requester 0.
- A requester that pulses req for less than one sampled edge may be missed; that is legal behaviour.

Test Plan:
1. Reset, then req=8'b0000_0100 -> one edge later grant=8'b0000_0100, grant_code=2, grant_valid=1. Drop req -> next edge all outputs 0.
2. Fairness: req=8'hFF held, each owner drops req for one edge after 2 cycles then re-raises -> grant_code sequence 0,1,2,...,7,0 with no idle cycle between owners.
3. Wrap: ptr at 6, req=8'b1000_0001 -> grant 7 first; on release grant 0, then back to 7.
4. Forced rotation with MAX_HOLD=4: req[3] held, req[5] raised at cycle 2 -> grant_code=3 for 4 cycles, then grant_code=5 with preempt=1 for one cycle only.
5. Limit with lone requester: only req[1] held for 40 cycles -> grant_code=1 throughout, preempt never asserted.
6. Mid-grant reset: assert rst asynchronously between edges while grant_code=5 -> outputs clear immediately. After release, req=8'hFF -> first grant_code=0 (ptr reset).
